// File: rtl/kb_pkg.sv
// Shared scan-code constants and session state encoding for the keyboard trainer.
package kb_pkg;

    localparam logic [7:0] KB_BREAK = 8'hF0;
    localparam logic [7:0] KB_EXT   = 8'hE0;
    localparam logic [7:0] KB_ENTER = 8'h5A;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_KEY,
        S_BRK,
        S_EXT,
        S_EXT_BRK,
        S_ISSUE,
        S_SETTLE,
        S_JUDGE,
        S_DONE
    } sess_state_t;

    // States in which incoming scan bytes are being parsed.
    function automatic logic is_key_wait(input sess_state_t s);
        return (s == S_WAIT_KEY) || (s == S_BRK) || (s == S_EXT) || (s == S_EXT_BRK);
    endfunction

    // States that belong to a running session.
    function automatic logic is_running(input sess_state_t s);
        return is_key_wait(s) || (s == S_ISSUE) || (s == S_SETTLE) || (s == S_JUDGE);
    endfunction

endpackage

// File: rtl/kb_prefix_filter.sv
// Scan-byte filter: swallows break (F0) and extended (E0) sequences, flags make codes.
module kb_prefix_filter
    import kb_pkg::*;
(
    input  logic        en_i,
    input  sess_state_t state_i,
    input  logic        kb_valid_i,
    input  logic [7:0]  kb_data_i,
    output logic        make_o,
    output logic [7:0]  code_o,
    output sess_state_t state_o
);

    always_comb begin
        make_o  = 1'b0;
        code_o  = kb_data_i;
        state_o = state_i;
        if (en_i && kb_valid_i) begin
            case (state_i)
                S_WAIT_KEY: begin
                    if (kb_data_i == KB_BREAK) begin
                        state_o = S_BRK;
                    end else if (kb_data_i == KB_EXT) begin
                        state_o = S_EXT;
                    end else begin
                        make_o  = 1'b1;
                        state_o = S_WAIT_KEY;
                    end
                end
                S_EXT: begin
                    state_o = (kb_data_i == KB_BREAK) ? S_EXT_BRK : S_WAIT_KEY;
                end
                S_BRK, S_EXT_BRK: begin
                    state_o = S_WAIT_KEY;
                end
                default: begin
                    state_o = state_i;
                end
            endcase
        end
    end

endmodule

// File: rtl/kb_session_ctrl.sv
// Keyboard-trainer session controller: feeds make codes to the sequence checker,
// tallies its verdicts and runs the countdown session timer.
module kb_session_ctrl
    import kb_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned SESSION_S = 60,
    parameter int unsigned CHK_LAT   = 4,
    parameter int unsigned CNT_W     = 10
) (
    input  logic             clk,
    input  logic             reset_signal,
    input  logic [7:0]       kb_data,
    input  logic             kb_valid,
    input  logic             start,
    output logic [7:0]       chk_code,
    output logic             chk_set,
    output logic             chk_reset,
    input  logic             chk_err,
    input  logic [7:0]       chk_expect,
    output logic [7:0]       expect_code,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [7:0]       sec_left,
    output logic             lamp,
    output logic             active,
    output logic             done
);

    localparam int unsigned PW = $clog2(TICK_DIV + 1);
    localparam int unsigned LW = $clog2(CHK_LAT + 1);

    sess_state_t      state_q, state_d;
    logic [LW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [7:0]       chk_code_q, chk_code_d;
    logic             chk_set_q, chk_set_d;
    logic             chk_reset_q, chk_reset_d;
    logic [7:0]       expect_q, expect_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [7:0]       sec_q, sec_d;
    logic             lamp_q, lamp_d;
    logic             active_q, active_d;
    logic             done_q, done_d;

    logic             tick;
    logic             sec_zero;
    logic             flt_make;
    logic [7:0]       flt_code;
    sess_state_t      flt_state;

    kb_prefix_filter u_filter (
        .en_i       (is_key_wait(state_q)),
        .state_i    (state_q),
        .kb_valid_i (kb_valid),
        .kb_data_i  (kb_data),
        .make_o     (flt_make),
        .code_o     (flt_code),
        .state_o    (flt_state)
    );

    assign tick = active_q && (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        chk_code_d  = chk_code_q;
        chk_reset_d = 1'b0;
        expect_d    = expect_q;
        hit_d       = hit_q;
        err_d       = err_q;
        lamp_d      = lamp_q;
        sec_d       = sec_q;

        if (!active_q || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (tick && (sec_q != 8'd0)) begin
            sec_d = sec_q - 8'd1;
        end
        // Expiry is judged on the post-tick value so the same-cycle tick takes effect.
        sec_zero = (sec_d == 8'd0);

        case (state_q)
            S_ARM: begin
                if (wait_cnt_q == LW'(CHK_LAT - 1)) begin
                    wait_cnt_d = '0;
                    state_d    = S_WAIT_KEY;
                end else begin
                    wait_cnt_d = wait_cnt_q + LW'(1);
                end
            end
            S_WAIT_KEY, S_BRK, S_EXT, S_EXT_BRK: begin
                // A make code arriving with the final tick is still issued; JUDGE then ends the session.
                if (flt_make) begin
                    chk_code_d = flt_code;
                    state_d    = S_ISSUE;
                end else if (sec_zero) begin
                    state_d = S_DONE;
                end else begin
                    state_d = flt_state;
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = S_SETTLE;
            end
            S_SETTLE: begin
                if (wait_cnt_q == LW'(CHK_LAT - 2)) begin
                    wait_cnt_d = '0;
                    state_d    = S_JUDGE;
                end else begin
                    wait_cnt_d = wait_cnt_q + LW'(1);
                end
            end
            S_JUDGE: begin
                expect_d = chk_expect;
                if (chk_code_q != KB_ENTER) begin
                    if (chk_err) begin
                        if (err_q != '1) err_d = err_q + CNT_W'(1);
                        lamp_d = 1'b1;
                    end else begin
                        if (hit_q != '1) hit_d = hit_q + CNT_W'(1);
                        lamp_d = 1'b0;
                    end
                end
                state_d = sec_zero ? S_DONE : S_WAIT_KEY;
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (start) begin
            state_d     = S_ARM;
            wait_cnt_d  = '0;
            presc_d     = '0;
            chk_code_d  = 8'h00;
            chk_reset_d = 1'b1;
            hit_d       = '0;
            err_d       = '0;
            lamp_d      = 1'b0;
            sec_d       = 8'(SESSION_S);
        end

        chk_set_d = (state_d == S_ISSUE);
        active_d  = is_running(state_d) && (state_d != S_ARM);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset_signal) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            presc_q     <= '0;
            chk_code_q  <= 8'h00;
            chk_set_q   <= 1'b0;
            chk_reset_q <= 1'b0;
            expect_q    <= 8'h00;
            hit_q       <= '0;
            err_q       <= '0;
            sec_q       <= 8'h00;
            lamp_q      <= 1'b0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            presc_q     <= presc_d;
            chk_code_q  <= chk_code_d;
            chk_set_q   <= chk_set_d;
            chk_reset_q <= chk_reset_d;
            expect_q    <= expect_d;
            hit_q       <= hit_d;
            err_q       <= err_d;
            sec_q       <= sec_d;
            lamp_q      <= lamp_d;
            active_q    <= active_d;
            done_q      <= done_d;
        end
    end

    assign chk_code    = chk_code_q;
    assign chk_set     = chk_set_q;
    assign chk_reset   = chk_reset_q;
    assign expect_code = expect_q;
    assign hit_cnt     = hit_q;
    assign err_cnt     = err_q;
    assign sec_left    = sec_q;
    assign lamp        = lamp_q;
    assign active      = active_q;
    assign done        = done_q;

endmodule

// File: tb/tb_kb_session_ctrl.sv
// Directed bench for kb_session_ctrl: a short-session instance with a checker model,
// plus a long-session instance used for counter saturation and mid-session restart.
module tb_kb_session_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_signal = 1'b1;

    // Main instance: TICK_DIV=8, SESSION_S=3, CHK_LAT=4.
    logic [7:0] kb_data = 8'h00;
    logic       kb_valid = 1'b0;
    logic       start = 1'b0;
    logic [7:0] chk_code;
    logic       chk_set, chk_reset;
    logic       chk_err;
    logic [7:0] chk_expect;
    logic [7:0] expect_code;
    logic [9:0] hit_cnt, err_cnt;
    logic [7:0] sec_left;
    logic       lamp, active, done;

    // Long-session instance: TICK_DIV=64, SESSION_S=200, CHK_LAT=3, checker always correct.
    logic [7:0] kb_data2 = 8'h00;
    logic       kb_valid2 = 1'b0;
    logic       start2 = 1'b0;
    logic [7:0] chk_code2;
    logic       chk_set2, chk_reset2;
    logic       chk_err2 = 1'b0;
    logic [7:0] chk_expect2 = 8'h2D;
    logic [7:0] expect_code2;
    logic [9:0] hit_cnt2, err_cnt2;
    logic [7:0] sec_left2;
    logic       lamp2, active2, done2;

    kb_session_ctrl #(.TICK_DIV(8), .SESSION_S(3), .CHK_LAT(4), .CNT_W(10)) u_dut (
        .clk(clk), .reset_signal(reset_signal), .kb_data(kb_data), .kb_valid(kb_valid),
        .start(start), .chk_code(chk_code), .chk_set(chk_set), .chk_reset(chk_reset),
        .chk_err(chk_err), .chk_expect(chk_expect), .expect_code(expect_code),
        .hit_cnt(hit_cnt), .err_cnt(err_cnt), .sec_left(sec_left), .lamp(lamp),
        .active(active), .done(done)
    );

    kb_session_ctrl #(.TICK_DIV(64), .SESSION_S(200), .CHK_LAT(3), .CNT_W(10)) u_dut2 (
        .clk(clk), .reset_signal(reset_signal), .kb_data(kb_data2), .kb_valid(kb_valid2),
        .start(start2), .chk_code(chk_code2), .chk_set(chk_set2), .chk_reset(chk_reset2),
        .chk_err(chk_err2), .chk_expect(chk_expect2), .expect_code(expect_code2),
        .hit_cnt(hit_cnt2), .err_cnt(err_cnt2), .sec_left(sec_left2), .lamp(lamp2),
        .active(active2), .done(done2)
    );

    // Checker model: the verdict queued with chk_set appears exactly CHK_LAT cycles later.
    logic       m_err = 1'b0;
    logic [7:0] m_exp = 8'h00;
    logic [8:0] p0, p1, p2, p3;
    always @(posedge clk) begin
        if (reset_signal || chk_reset) begin
            p0 <= '0; p1 <= '0; p2 <= '0; p3 <= '0;
        end else begin
            if (chk_set) p0 <= {m_err, m_exp};
            p1 <= p0;
            p2 <= p1;
            p3 <= p2;
        end
    end
    assign chk_err    = p3[8];
    assign chk_expect = p3[7:0];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Presents one byte; returns 1 if chk_set was seen the cycle after.
    task automatic send_byte(input logic [7:0] b, output logic set_seen);
        kb_data  = b;
        kb_valid = 1'b1;
        step(1);
        kb_valid = 1'b0;
        set_seen = chk_set;
    endtask

    task automatic key2();
        kb_data2  = 8'h1B;
        kb_valid2 = 1'b1;
        step(1);
        kb_valid2 = 1'b0;
        step(4);
    endtask

    initial begin
        logic s;
        logic any_set;
        logic [7:0] pre [7];
        pre[0] = 8'hF0; pre[1] = 8'h1B; pre[2] = 8'hE0; pre[3] = 8'h75;
        pre[4] = 8'hE0; pre[5] = 8'hF0; pre[6] = 8'h75;

        step(2);
        reset_signal = 1'b0;
        step(1);
        chk("rst_chk_code", chk_code, 8'h00);
        chk("rst_chk_set", chk_set, 1'b0);
        chk("rst_chk_reset", chk_reset, 1'b0);
        chk("rst_lamp", lamp, 1'b0);
        chk("rst_active", active, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hit", hit_cnt, 10'd0);
        chk("rst_err", err_cnt, 10'd0);
        chk("rst_sec", sec_left, 8'd0);
        chk("rst_expect", expect_code, 8'h00);

        // Session 1: first key, prefix sequences.
        pulse_start();
        chk("s1_chk_reset", chk_reset, 1'b1);
        chk("s1_sec_load", sec_left, 8'd3);
        step(1);
        chk("s1_chk_reset_off", chk_reset, 1'b0);
        step(2);
        chk("s1_arm_inactive", active, 1'b0);
        step(1);
        chk("s1_active", active, 1'b1);
        chk("s1_arm_code", chk_code, 8'h00);
        m_err = 1'b0; m_exp = 8'h1C;
        send_byte(8'h1B, s);
        chk("k1_set_rise", s, 1'b1);
        chk("k1_code", chk_code, 8'h1B);
        step(1);
        chk("k1_set_one", chk_set, 1'b0);
        step(3);
        chk("k1_latency", hit_cnt, 10'd0);
        step(1);
        chk("k1_hit", hit_cnt, 10'd1);
        chk("k1_err", err_cnt, 10'd0);
        chk("k1_lamp", lamp, 1'b0);
        chk("k1_expect", expect_code, 8'h1C);
        any_set = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send_byte(pre[i], s);
            any_set = any_set | s;
        end
        chk("prefix_no_set", any_set, 1'b0);
        chk("prefix_hit", hit_cnt, 10'd1);
        chk("prefix_err", err_cnt, 10'd0);
        chk("prefix_sec", sec_left, 8'd2);

        // Session 2: restart mid-session, wrong/correct/enter keys, expiry with a key in flight.
        pulse_start();
        chk("s2_chk_reset", chk_reset, 1'b1);
        chk("s2_hit_clr", hit_cnt, 10'd0);
        chk("s2_sec", sec_left, 8'd3);
        step(4);
        m_err = 1'b1; m_exp = 8'h1B;
        send_byte(8'h1C, s);
        chk("k_wrong_set", s, 1'b1);
        step(5);
        chk("k_wrong_err", err_cnt, 10'd1);
        chk("k_wrong_lamp", lamp, 1'b1);
        chk("k_wrong_hit", hit_cnt, 10'd0);
        chk("k_wrong_expect", expect_code, 8'h1B);
        m_err = 1'b0; m_exp = 8'h2D;
        send_byte(8'h1B, s);
        step(5);
        chk("k_right_hit", hit_cnt, 10'd1);
        chk("k_right_lamp", lamp, 1'b0);
        chk("k_right_expect", expect_code, 8'h2D);
        m_err = 1'b1; m_exp = 8'h33;
        send_byte(8'h5A, s);
        chk("enter_set", s, 1'b1);
        chk("enter_code", chk_code, 8'h5A);
        step(5);
        chk("enter_hit", hit_cnt, 10'd1);
        chk("enter_err", err_cnt, 10'd1);
        chk("enter_lamp", lamp, 1'b0);
        chk("enter_expect", expect_code, 8'h33);
        step(4);
        chk("late_sec1", sec_left, 8'd1);
        m_err = 1'b0; m_exp = 8'h44;
        send_byte(8'h1B, s);
        chk("late_set", s, 1'b1);
        step(1);
        chk("late_sec0", sec_left, 8'd0);
        chk("late_active", active, 1'b1);
        step(3);
        chk("late_not_done", done, 1'b0);
        step(1);
        chk("late_hit", hit_cnt, 10'd2);
        chk("late_done", done, 1'b1);
        chk("late_inactive", active, 1'b0);
        chk("late_expect", expect_code, 8'h44);
        send_byte(8'h1B, s);
        chk("done_ignore_set", s, 1'b0);
        step(5);
        chk("done_ignore_hit", hit_cnt, 10'd2);
        chk("done_hold", done, 1'b1);

        // Session 3: idle countdown.
        pulse_start();
        chk("s3_done_clr", done, 1'b0);
        step(4);
        step(7);
        chk("idle_sec3", sec_left, 8'd3);
        step(1);
        chk("idle_sec2", sec_left, 8'd2);
        step(8);
        chk("idle_sec1", sec_left, 8'd1);
        step(7);
        chk("idle_active_end", active, 1'b1);
        chk("idle_not_done", done, 1'b0);
        step(1);
        chk("idle_sec0", sec_left, 8'd0);
        chk("idle_done", done, 1'b1);
        chk("idle_inactive", active, 1'b0);

        // Session 4: reset while SETTLE.
        pulse_start();
        step(4);
        m_err = 1'b0; m_exp = 8'h1C;
        send_byte(8'h1B, s);
        step(5);
        chk("s4_hit", hit_cnt, 10'd1);
        send_byte(8'h1C, s);
        step(1);
        reset_signal = 1'b1;
        step(1);
        reset_signal = 1'b0;
        chk("mid_rst_code", chk_code, 8'h00);
        chk("mid_rst_set", chk_set, 1'b0);
        chk("mid_rst_hit", hit_cnt, 10'd0);
        chk("mid_rst_expect", expect_code, 8'h00);
        chk("mid_rst_sec", sec_left, 8'd0);
        chk("mid_rst_active", active, 1'b0);
        step(6);
        chk("post_rst_idle_hit", hit_cnt, 10'd0);
        chk("post_rst_idle_active", active, 1'b0);
        send_byte(8'h1B, s);
        chk("idle_ignore_set", s, 1'b0);

        // Long-session instance: restart with hit_cnt=5, then saturation.
        start2 = 1'b1;
        step(1);
        start2 = 1'b0;
        step(3);
        chk("l_active", active2, 1'b1);
        for (int i = 0; i < 5; i++) key2();
        chk("l_hit5", hit_cnt2, 10'd5);
        start2 = 1'b1;
        step(1);
        start2 = 1'b0;
        chk("l_restart_chk_reset", chk_reset2, 1'b1);
        chk("l_restart_hit", hit_cnt2, 10'd0);
        chk("l_restart_sec", sec_left2, 8'd200);
        step(3);
        for (int i = 0; i < 1022; i++) key2();
        chk("l_hit1022", hit_cnt2, 10'd1022);
        key2();
        chk("l_hit1023", hit_cnt2, 10'd1023);
        key2();
        chk("l_sat", hit_cnt2, 10'd1023);
        chk("l_err", err_cnt2, 10'd0);
        chk("l_expect", expect_code2, 8'h2D);
        chk("l_still_active", active2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/kb_session_ctrl.md
# kb_session_ctrl

Session controller for the keyboard trainer. It takes raw PS/2 scan-code bytes from the keyboard receiver, strips break (F0) and extended (E0) sequences, and presents each make code to the sequence checker with a one-cycle set strobe. It then samples the checker's verdict and keeps hit/error tallies, an error lamp and a countdown session timer for the display logic.

## Interface
Parameters:
- TICK_DIV, 50_000_000, clk cycles per timer second
- SESSION_S, 60, session length in seconds (1..255)
- CHK_LAT, 4, cycles from chk_set to a valid chk_err/chk_expect (≥3)
- CNT_W, 10, hit/error counter width

Ports:
- clk  in  1  system clock
- reset_signal  in  1  reset; one clock; reset is synchronous and active-high
- kb_data  in  8  received scan-code byte
- kb_valid  in  1  one-cycle strobe, kb_data valid
- start  in  1  one-cycle pulse, begin/restart session
- chk_code  out  8  code presented to checker
- chk_set  out  1  one-cycle advance strobe to checker
- chk_reset  out  1  one-cycle checker reset
- chk_err  in  1  checker mismatch flag
- chk_expect  in  8  checker's next expected code
- expect_code  out  8  registered chk_expect, for display
- hit_cnt  out  CNT_W  correct keystrokes
- err_cnt  out  CNT_W  wrong keystrokes
- sec_left  out  8  seconds remaining
- lamp  out  1  error lamp
- active  out  1  session running
- done  out  1  session finished, held until start

## Operation
- States: IDLE, ARM, WAIT_KEY, BRK, EXT, EXT_BRK, ISSUE, SETTLE, JUDGE, DONE.
- IDLE/DONE: kb_valid is ignored. On start: pulse chk_reset, clear counters and lamp, load sec_left=SESSION_S, clear done, go to ARM.
- ARM: CHK_LAT cycles with chk_code=8'h00, then enter WAIT_KEY with active=1.
- WAIT_KEY on kb_valid:
  - F0 → BRK.
  - E0 → EXT.
  - Any other byte → latch into chk_code, go to ISSUE.
- BRK: the next valid byte is discarded, return to WAIT_KEY.
- EXT: F0 → EXT_BRK. Any other byte is discarded, return to WAIT_KEY.
- EXT_BRK: the next byte is discarded, return to WAIT_KEY.
- ISSUE: chk_set=1 for exactly one cycle, then SETTLE.
- SETTLE: count CHK_LAT-1 cycles, then JUDGE. kb_valid is dropped in ISSUE, SETTLE and JUDGE.
- JUDGE: sample chk_err and chk_expect. chk_code is held from ISSUE through JUDGE.
  - chk_code==8'h5A (Enter): counters and lamp unchanged.
  - chk_err=1: err_cnt+1, lamp=1.
  - Otherwise: hit_cnt+1, lamp=0.
  - expect_code ← chk_expect in every case, then WAIT_KEY.
- Counters saturate at 2^CNT_W−1.
- Timer: the prescaler runs only while active. On a tick, sec_left decrements. When sec_left reaches 0:
  - in WAIT_KEY/BRK/EXT/EXT_BRK: go to DONE immediately;
  - in ISSUE/SETTLE/JUDGE: JUDGE completes and is counted first, then DONE.
- DONE: active=0, done=1. Counters, lamp and expect_code hold.
- start in any state except IDLE/DONE restarts the session exactly as from IDLE. The prescaler is cleared.
- reset_signal at any point returns to IDLE and forces every output to its reset value.

## Timing
- Reset values: chk_code 8'h00; chk_set, chk_reset, lamp, active, done 0; hit_cnt, err_cnt, sec_left, expect_code 0.
- All outputs are registered.
- chk_set rises one cycle after the accepting kb_valid.
- JUDGE occurs CHK_LAT cycles after chk_set.
- Counters and lamp update one cycle after JUDGE.
- Key-to-count latency is CHK_LAT+2 cycles.
- chk_reset is high the cycle after start. ARM ends CHK_LAT cycles later.
- Tick and kb_valid in the same cycle are both handled.
- Tick and start in the same cycle: start wins.

## Structure
- Shared package kb_pkg holds:
  - scan constants: KB_BREAK=8'hF0, KB_EXT=8'hE0, KB_ENTER=8'h5A;
  - the session state encoding (4-bit).
- One natural sub-module, kb_prefix_filter: the WAIT_KEY/BRK/EXT/EXT_BRK byte filter. It outputs a make-code strobe and code, and takes an enable input that is low outside WAIT_KEY.
- Timer prescaler and counters stay in kb_session_ctrl.

## Test plan
- Run with TICK_DIV=8, SESSION_S=3, CHK_LAT=4, and a behavioural checker model.
- start, kb 1B, checker err=0, expect=1C → chk_set one pulse 1 cycle after kb_valid; hit_cnt=1, err_cnt=0, lamp=0, expect_code=1C.
- F0,1B and E0,75 and E0,F0,75 byte sequences → no chk_set; counters unchanged.
- Wrong key 1C (err=1) → err_cnt=1, lamp=1. Next correct key → hit_cnt=1, lamp=0. Enter 5A → chk_set pulses, counters unchanged.
- Idle for 24 active cycles → sec_left 3,2,1,0, then done=1, active=0. A key issued 2 cycles before expiry is still counted. A kb_valid after done → ignored.
- Hold hit_cnt at 1023 (CNT_W=10), one more correct key → stays 1023.
- reset_signal during SETTLE → all outputs 0 next cycle, state IDLE. start mid-session with hit_cnt=5 → chk_reset pulse, counters 0, sec_left=3.
